// File: rtl/game_flow_controller.sv
// Frogger phase sequencer: idle, start countdown, play, hit recovery, level pause, game over.
// Owns the thermometer life counter and frame-based phase timers.
module game_flow_controller #(
   parameter int unsigned C_START_FRAMES = 60,
   parameter int unsigned C_HIT_FRAMES   = 90,
   parameter int unsigned C_LEVEL_FRAMES = 30,
   parameter int unsigned C_OVER_FRAMES  = 120
) (
   input  logic       i_Clk,
   input  logic       i_Reset,
   input  logic       i_Frame_Tick,
   input  logic       i_Start,
   input  logic       i_Has_Collided,
   input  logic       i_Level_Up,
   output logic       o_Game_Active,
   output logic       o_Freeze,
   output logic       o_Respawn,
   output logic       o_Blink,
   output logic [2:0] o_Lives,
   output logic [2:0] o_State
);

   // state   | meaning
   // IDLE    | attract screen, waits for a fresh start edge
   // START   | countdown before play, world frozen
   // RUNNING | frog movement enabled
   // HIT     | non-fatal hit, frog blinks, world frozen
   // LEVEL   | pause after reaching the top row
   // OVER    | game-over display, then back to IDLE
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      RUNNING = 3'd2,
      HIT     = 3'd3,
      LEVEL   = 3'd4,
      OVER    = 3'd5
   } state_t;

   localparam logic [7:0] START_LAST = 8'(C_START_FRAMES - 1);
   localparam logic [7:0] HIT_LAST   = 8'(C_HIT_FRAMES - 1);
   localparam logic [7:0] LEVEL_LAST = 8'(C_LEVEL_FRAMES - 1);
   localparam logic [7:0] OVER_LAST  = 8'(C_OVER_FRAMES - 1);

   state_t     state;
   logic [7:0] frame_cnt;
   logic [7:0] phase_last;
   logic       start_q;
   logic       coll_q;
   logic       start_rise;
   logic       coll_rise;
   logic       expired;

   assign start_rise = i_Start & ~start_q;
   assign coll_rise  = i_Has_Collided & ~coll_q;

   always_comb begin
      phase_last = 8'd0;
      case (state)
         START:   phase_last = START_LAST;
         HIT:     phase_last = HIT_LAST;
         LEVEL:   phase_last = LEVEL_LAST;
         OVER:    phase_last = OVER_LAST;
         default: phase_last = 8'd0;
      endcase
   end

   assign expired = i_Frame_Tick && (frame_cnt == phase_last);

   // Previous-sample registers reset high so inputs held through reset give no edge.
   always_ff @(posedge i_Clk) begin
      if (i_Reset) begin
         state     <= IDLE;
         frame_cnt <= 8'd0;
         o_Lives   <= 3'b111;
         o_Respawn <= 1'b0;
         start_q   <= 1'b1;
         coll_q    <= 1'b1;
      end else begin
         start_q   <= i_Start;
         coll_q    <= i_Has_Collided;
         o_Respawn <= 1'b0;
         if (i_Frame_Tick) frame_cnt <= frame_cnt + 8'd1;
         case (state)
            IDLE: begin
               if (start_rise) begin
                  o_Lives   <= 3'b111;
                  o_Respawn <= 1'b1;
                  state     <= START;
                  frame_cnt <= 8'd0;
               end
            end
            START: begin
               if (expired) begin
                  state     <= RUNNING;
                  frame_cnt <= 8'd0;
               end
            end
            RUNNING: begin
               if (coll_rise) begin
                  o_Lives   <= o_Lives >> 1;
                  state     <= (o_Lives == 3'b001) ? OVER : HIT;
                  frame_cnt <= 8'd0;
               end else if (i_Level_Up) begin
                  state     <= LEVEL;
                  frame_cnt <= 8'd0;
               end
            end
            HIT: begin
               if (expired) begin
                  state     <= RUNNING;
                  o_Respawn <= 1'b1;
                  frame_cnt <= 8'd0;
               end
            end
            LEVEL: begin
               if (expired) begin
                  state     <= RUNNING;
                  frame_cnt <= 8'd0;
               end
            end
            OVER: begin
               o_Lives <= 3'b000;
               if (expired) begin
                  state     <= IDLE;
                  frame_cnt <= 8'd0;
               end
            end
            default: begin
               state     <= IDLE;
               frame_cnt <= 8'd0;
            end
         endcase
      end
   end

   assign o_State       = state;
   assign o_Game_Active = (state == RUNNING);
   assign o_Freeze      = (state == START) || (state == HIT) ||
                          (state == LEVEL) || (state == OVER);
   assign o_Blink       = (state == HIT) ? frame_cnt[3] : 1'b1;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: directed phase walk-through, then random stimulus
// compared every cycle against a phase/life-count reference model.
module tb_game_flow_controller;
   localparam int SF = 2, HF = 3, LF = 2, OF = 2;

   logic       i_Clk = 1'b0;
   logic       i_Reset = 1'b1;
   logic       i_Frame_Tick = 1'b0;
   logic       i_Start = 1'b0;
   logic       i_Has_Collided = 1'b0;
   logic       i_Level_Up = 1'b0;
   logic       o_Game_Active, o_Freeze, o_Respawn, o_Blink;
   logic [2:0] o_Lives, o_State;

   game_flow_controller #(
      .C_START_FRAMES(SF), .C_HIT_FRAMES(HF),
      .C_LEVEL_FRAMES(LF), .C_OVER_FRAMES(OF)
   ) dut (
      .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Frame_Tick(i_Frame_Tick),
      .i_Start(i_Start), .i_Has_Collided(i_Has_Collided), .i_Level_Up(i_Level_Up),
      .o_Game_Active(o_Game_Active), .o_Freeze(o_Freeze), .o_Respawn(o_Respawn),
      .o_Blink(o_Blink), .o_Lives(o_Lives), .o_State(o_State)
   );

   always #20 i_Clk = ~i_Clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: phase number, ticks seen since entering the phase, lives as a count.
   int m_phase = 0, m_ticks = 0, m_lives = 3, m_resp = 0;
   int m_start_prev = 1, m_coll_prev = 1;

   function automatic int phase_frames(input int ph);
      case (ph)
         1: return SF;
         3: return HF;
         4: return LF;
         5: return OF;
         default: return 0;
      endcase
   endfunction

   task automatic model_update();
      int  nxt;
      bit  srise, crise, done;
      if (i_Reset) begin
         m_phase = 0; m_ticks = 0; m_lives = 3; m_resp = 0;
         m_start_prev = 1; m_coll_prev = 1;
         return;
      end
      srise = i_Start && (m_start_prev == 0);
      crise = i_Has_Collided && (m_coll_prev == 0);
      m_start_prev = int'(i_Start);
      m_coll_prev  = int'(i_Has_Collided);
      done = i_Frame_Tick && (m_ticks + 1 == phase_frames(m_phase));
      m_resp = 0;
      nxt = m_phase;
      case (m_phase)
         0: if (srise) begin m_lives = 3; nxt = 1; m_resp = 1; end
         1: if (done) nxt = 2;
         2: if (crise) begin
               nxt = (m_lives == 1) ? 5 : 3;
               if (m_lives > 0) m_lives--;
            end else if (i_Level_Up) nxt = 4;
         3: if (done) begin nxt = 2; m_resp = 1; end
         4: if (done) nxt = 2;
         5: begin m_lives = 0; if (done) nxt = 0; end
         default: nxt = 0;
      endcase
      if (nxt != m_phase) m_ticks = 0;
      else if (i_Frame_Tick) m_ticks = (m_ticks + 1) % 256;
      m_phase = nxt;
   endtask

   task automatic step();
      @(posedge i_Clk);
      model_update();
      #1;
      check_eq("state",  8'(o_State), 8'(m_phase));
      check_eq("lives",  8'(o_Lives), 8'((1 << m_lives) - 1));
      check_eq("active", 8'(o_Game_Active), 8'(m_phase == 2));
      check_eq("freeze", 8'(o_Freeze), 8'(m_phase inside {1, 3, 4, 5}));
      check_eq("respawn", 8'(o_Respawn), 8'(m_resp));
      check_eq("blink",  8'(o_Blink), (m_phase == 3) ? 8'((m_ticks >> 3) & 1) : 8'd1);
   endtask

   task automatic tick(input int n);
      for (int k = 0; k < n; k++) begin
         i_Frame_Tick = 1'b1; step(); i_Frame_Tick = 1'b0;
      end
   endtask

   task automatic collide();
      i_Has_Collided = 1'b1; step(); i_Has_Collided = 1'b0; step();
   endtask

   initial begin
      // Start held through reset release must not start a game.
      i_Reset = 1'b1; i_Start = 1'b1;
      step(); step();
      check_eq("rst_state", 8'(o_State), 8'd0);
      check_eq("rst_blink", 8'(o_Blink), 8'd1);
      i_Reset = 1'b0;
      step(); step(); step();
      check_eq("idle_held", 8'(o_State), 8'd0);
      i_Start = 1'b0; step();
      i_Start = 1'b1; step();
      check_eq("start_state", 8'(o_State), 8'd1);
      check_eq("start_resp", 8'(o_Respawn), 8'd1);
      check_eq("start_lives", 8'(o_Lives), 8'd7);
      step();
      check_eq("resp_one_cycle", 8'(o_Respawn), 8'd0);
      tick(2);
      check_eq("run_state", 8'(o_State), 8'd2);
      check_eq("run_active", 8'(o_Game_Active), 8'd1);

      // Held collision costs one life.
      i_Has_Collided = 1'b1;
      for (int k = 0; k < 10; k++) step();
      check_eq("hold_lives", 8'(o_Lives), 8'd3);
      check_eq("hold_state", 8'(o_State), 8'd3);
      i_Has_Collided = 1'b0;
      tick(3);
      check_eq("hit_exit_state", 8'(o_State), 8'd2);
      check_eq("hit_exit_resp", 8'(o_Respawn), 8'd1);
      collide();
      check_eq("second_hit", 8'(o_Lives), 8'd1);
      tick(3);
      collide();
      check_eq("over_state", 8'(o_State), 8'd5);
      check_eq("over_lives", 8'(o_Lives), 8'd0);
      tick(2);
      check_eq("over_idle", 8'(o_State), 8'd0);
      step(); step();
      check_eq("idle_lives0", 8'(o_Lives), 8'd0);

      // Collision beats level-up; level-up alone pauses without respawn.
      i_Start = 1'b0; step(); i_Start = 1'b1; step();
      tick(2);
      i_Level_Up = 1'b1; i_Has_Collided = 1'b1; step();
      check_eq("coll_wins", 8'(o_State), 8'd3);
      check_eq("coll_wins_lives", 8'(o_Lives), 8'd3);
      i_Level_Up = 1'b0; i_Has_Collided = 1'b0;
      tick(3);
      i_Level_Up = 1'b1; step(); i_Level_Up = 1'b0;
      check_eq("level_state", 8'(o_State), 8'd4);
      collide();
      check_eq("level_coll_lives", 8'(o_Lives), 8'd3);
      tick(2);
      check_eq("level_exit", 8'(o_State), 8'd2);
      check_eq("level_no_resp", 8'(o_Respawn), 8'd0);

      // Collision during HIT ignored; reset at counter 1 in HIT.
      collide();
      collide();
      check_eq("hit_coll_lives", 8'(o_Lives), 8'd1);
      tick(1);
      i_Reset = 1'b1; step();
      check_eq("midrst_state", 8'(o_State), 8'd0);
      check_eq("midrst_lives", 8'(o_Lives), 8'd7);
      check_eq("midrst_freeze", 8'(o_Freeze), 8'd0);
      i_Reset = 1'b0;

      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(9) == 0) i_Start = ~i_Start;
         if ($urandom_range(5) == 0) i_Has_Collided = ~i_Has_Collided;
         i_Level_Up   = ($urandom_range(11) == 0);
         i_Frame_Tick = ($urandom_range(2) == 0);
         i_Reset      = ($urandom_range(299) == 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/game_flow_controller.md
# game_flow_controller

Sequences the Frogger game phases (attract/idle, start countdown, play, hit recovery, level-up pause, game over) and owns the life counter. It sits between the debounced switches, Collisions and Character_Control on one side and the movement/display blocks on the other. It gates play with o_Game_Active, freezes the world with o_Freeze, and requests a frog respawn with o_Respawn. All timing is counted in frames from a one-cycle-per-frame tick.

## Interface
Parameters:
- C_START_FRAMES, 60: frames of start countdown before play (1..255)
- C_HIT_FRAMES, 90: frames of freeze/blink after a non-fatal hit (1..255)
- C_LEVEL_FRAMES, 30: frames of pause after a level-up (1..255)
- C_OVER_FRAMES, 120: frames of game-over display before returning to idle (1..255)

Ports:
- i_Clk  in  1  system clock (25 MHz pixel clock); the block has one clock
- i_Reset  in  1  synchronous, active-high reset
- i_Frame_Tick  in  1  one-cycle pulse per video frame
- i_Start  in  1  start request (all four debounced switches ANDed), level
- i_Has_Collided  in  1  frog/car overlap, level
- i_Level_Up  in  1  one-cycle pulse when frog reaches the top row
- o_Game_Active  out  1  high only in RUNNING; enables frog movement
- o_Freeze  out  1  high in START, HIT, LEVEL, OVER; cars hold position
- o_Respawn  out  1  one-cycle pulse: frog returns to base position
- o_Blink  out  1  frog sprite visibility in HIT (frame counter bit 3); 1 elsewhere
- o_Lives  out  3  thermometer life count (111, 011, 001, 000); drives LEDs 2-4
- o_State  out  3  current state encoding, for debug and display

## Operation
- States and encoding: IDLE=0, START=1, RUNNING=2, HIT=3, LEVEL=4, OVER=5. Codes 6-7 are illegal and return to IDLE on the next cycle.
- Frame counter: 8 bits. It increments on i_Frame_Tick and clears to 0 on every state transition.
  - "Expires" means i_Frame_Tick=1 while counter == PARAM-1.
- Edge detectors:
  - i_Start and i_Has_Collided are each registered every cycle, in all states.
  - A rising edge is current=1 and previous=0.
  - On reset, both previous-sample registers are set to 1. Inputs held high through reset therefore never trigger an edge.
- IDLE:
  - On a start rising edge: o_Lives <= 111, next state START, o_Respawn pulse.
  - All other inputs are ignored.
- START: on expiry, go to RUNNING.
- RUNNING:
  - On a collision rising edge: o_Lives <= o_Lives >> 1.
    - If the old o_Lives == 001, go to OVER.
    - Otherwise go to HIT.
  - Else if i_Level_Up: go to LEVEL. Lives are unchanged.
  - Collision wins over level-up in the same cycle.
- HIT: collisions and level-ups are ignored. On expiry, go to RUNNING with an o_Respawn pulse.
- LEVEL: collisions are ignored. On expiry, go to RUNNING; no respawn (Character_Control already repositions the frog).
- OVER: o_Lives stays 000. On expiry, go to IDLE. i_Start is ignored until the state is IDLE, and a fresh rising edge is required there.
- o_Lives never underflows below 000.

## Timing
- Reset values: state IDLE, counter 0, o_Lives 111, o_Game_Active 0, o_Freeze 0, o_Respawn 0, o_Blink 1, o_State 000.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to any output.
- Latency: an input event sampled on edge N appears on the outputs after edge N (state and outputs update together, one clock).
- o_Respawn is high for exactly the first cycle in which the new state (START or RUNNING) is visible.
- HIT duration: exactly C_HIT_FRAMES frame ticks, counted from the first tick after entry. A tick coinciding with the entry cycle is not counted.
- Reset mid-operation: the next cycle is IDLE with reset values; any pending respawn pulse is dropped.
- i_Frame_Tick while in IDLE or RUNNING has no effect beyond the counter.

## Test plan
Benches use parameters C_START_FRAMES=2, C_HIT_FRAMES=3, C_LEVEL_FRAMES=2, C_OVER_FRAMES=2.
- Start with i_Start held high across reset release -> stays IDLE. Drop i_Start, then raise it -> next cycle o_State=1, o_Respawn=1 for one cycle, o_Lives=111. After 2 ticks -> o_State=2, o_Game_Active=1.
- In RUNNING, collision pulse -> o_Lives=011, o_State=3, o_Freeze=1. Collision held high for 10 cycles costs one life only. After 3 ticks -> RUNNING with o_Respawn=1.
- Three separate collisions from 111 -> 011, 001, then 000 with o_State=5. After 2 ticks -> o_State=0 and o_Lives remains 000 until the next start.
- In RUNNING, i_Level_Up and collision rising edge in the same cycle -> HIT and o_Lives decremented, not LEVEL. i_Level_Up alone -> o_State=4 for 2 ticks, then 2, with no o_Respawn and lives unchanged.
- Collision during HIT and during LEVEL -> o_Lives unchanged. o_Blink follows counter bit 3 in HIT and is 1 otherwise.
- Assert i_Reset while in HIT at counter=1 -> next cycle o_State=0, o_Lives=111, o_Respawn=0, o_Freeze=0.
